// File: rtl/server_task_executor.sv
// Three-server task executor: queues per-server assignments, runs each for a fixed
// service time, reports completions round-robin over valid/ack. Option: TASK_EXEC_ERR_EN.
//
// state   | meaning
// IDLE    | nothing running; starts work when pending > 0
// BUSY    | task running, timer counting down to 0
// DONE    | task finished, waiting for its completion report to be acked
module server_task_executor #(
    parameter int SERVICE_CYCLES = 4,
    parameter int QUEUE_MAX      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       assign_valid,
    input  logic [1:0] assign_server,
    output logic [2:0] assign_ready,
    output logic       done_valid,
    output logic [1:0] done_server,
    input  logic       done_ack,
    output logic [3:0] server3_pending,
    output logic [3:0] server2_pending,
    output logic [3:0] server1_pending,
    output logic [2:0] busy,
    output logic       all_idle
`ifdef TASK_EXEC_ERR_EN
    ,
    output logic [1:0] err_status
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic [3:0] TIMER_LOAD = 4'(SERVICE_CYCLES - 1);
    localparam logic [3:0] QMAX_C     = 4'(QUEUE_MAX);

    state_t     state_q [3];
    logic [3:0] timer_q [3];
    logic [3:0] pend_q  [3];
    logic [3:0] pend_d  [3];
    logic       done_valid_q;
    logic [1:0] done_server_q;
    logic [1:0] rr_q;

    logic [2:0] acc;
    logic [2:0] ret;
    logic [2:0] cand;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic       report_free;
    logic       full_hit;

    function automatic logic [1:0] rr_pick(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 3) s = s - 3;
        if (s >= 3) s = s - 3;
        return 2'(s);
    endfunction

    always_comb begin
        acc       = '0;
        ret       = '0;
        cand      = '0;
        full_hit  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            assign_ready[i] = (pend_q[i] < QMAX_C);
            acc[i] = assign_valid && (assign_server == 2'(i)) && assign_ready[i];
            if (assign_valid && (assign_server == 2'(i)) && !assign_ready[i])
                full_hit = 1'b1;
            ret[i] = done_valid_q && done_ack && (done_server_q == 2'(i));
            pend_d[i] = pend_q[i];
            if (acc[i] && !ret[i])
                pend_d[i] = pend_q[i] + 4'd1;
            else if (ret[i] && !acc[i])
                pend_d[i] = pend_q[i] - 4'd1;
            // A server finishing on this edge is eligible so the report appears without an extra cycle
            cand[i] = ((state_q[i] == ST_DONE) && !ret[i]) ||
                      ((state_q[i] == ST_BUSY) && (timer_q[i] == 4'd0));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            if (!grant_vld && cand[rr_pick(rr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_pick(rr_q, k);
            end
        end
    end

    assign report_free = !done_valid_q || done_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                pend_q[i]  <= '0;
            end
            done_valid_q  <= 1'b0;
            done_server_q <= 2'd0;
            rr_q          <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pend_q[i] <= pend_d[i];
                case (state_q[i])
                    ST_IDLE: begin
                        if (pend_q[i] != 4'd0) begin
                            state_q[i] <= ST_BUSY;
                            timer_q[i] <= TIMER_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (timer_q[i] == 4'd0)
                            state_q[i] <= ST_DONE;
                        else
                            timer_q[i] <= timer_q[i] - 4'd1;
                    end
                    ST_DONE: begin
                        if (ret[i]) begin
                            if (pend_d[i] != 4'd0) begin
                                state_q[i] <= ST_BUSY;
                                timer_q[i] <= TIMER_LOAD;
                            end else begin
                                state_q[i] <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
            if (report_free) begin
                done_valid_q <= grant_vld;
                if (grant_vld) begin
                    done_server_q <= grant_idx;
                    rr_q          <= grant_idx;
                end
            end
        end
    end

`ifdef TASK_EXEC_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 2'b00;
        end else begin
            if (assign_valid && (assign_server == 2'd3))
                err_q[0] <= 1'b1;
            if (full_hit)
                err_q[1] <= 1'b1;
        end
    end

    assign err_status = err_q;
`else
    logic unused_full_hit;
    assign unused_full_hit = full_hit;
`endif

    always_comb begin
        busy = '0;
        for (int i = 0; i < 3; i++)
            busy[i] = (state_q[i] == ST_BUSY);
    end

    assign done_valid      = done_valid_q;
    assign done_server     = done_server_q;
    assign server3_pending = pend_q[0];
    assign server2_pending = pend_q[1];
    assign server1_pending = pend_q[2];
    assign all_idle        = (pend_q[0] == 4'd0) && (pend_q[1] == 4'd0) && (pend_q[2] == 4'd0);

endmodule

// File: tb/tb_server_task_executor.sv
// Self-checking bench for server_task_executor: completion order is checked against
// a queue of expected server indices filled as assignments are driven.
module tb_server_task_executor;

    logic       clk;
    logic       reset;
    logic       assign_valid;
    logic [1:0] assign_server;
    logic [2:0] assign_ready;
    logic       done_valid;
    logic [1:0] done_server;
    logic       done_ack;
    logic [3:0] server3_pending;
    logic [3:0] server2_pending;
    logic [3:0] server1_pending;
    logic [2:0] busy;
    logic       all_idle;
`ifdef TASK_EXEC_ERR_EN
    logic [1:0] err_status;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];

    server_task_executor #(
        .SERVICE_CYCLES(4),
        .QUEUE_MAX     (15)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .assign_valid   (assign_valid),
        .assign_server  (assign_server),
        .assign_ready   (assign_ready),
        .done_valid     (done_valid),
        .done_server    (done_server),
        .done_ack       (done_ack),
        .server3_pending(server3_pending),
        .server2_pending(server2_pending),
        .server1_pending(server1_pending),
        .busy           (busy),
        .all_idle       (all_idle)
`ifdef TASK_EXEC_ERR_EN
        ,
        .err_status     (err_status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle, ahead of the edge that consumes them
    always @(negedge clk) begin
        if (reset && done_valid && done_ack) begin
            if (exp_q.size() == 0)
                chk_val("sb_unexpected_report", 32'(exp_q.size()), 32'd1);
            else
                chk_val("sb_order", 32'(done_server), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        assign_valid  = 1'b0;
        assign_server = 2'd0;
        done_ack      = 1'b0;
        reset         = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send(input logic [1:0] srv);
        assign_valid  = 1'b1;
        assign_server = srv;
        tick();
        assign_valid  = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        done_ack = 1'b1;
        while (!all_idle && n < budget) begin
            tick();
            n++;
        end
        done_ack = 1'b0;
        chk_val({tag, "_drained"}, 32'(all_idle), 32'd1);
        chk_val({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk_val({tag, "_dv_after"}, 32'(done_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dv_seen;

        reset = 1'b0;
        assign_valid = 1'b0;
        assign_server = 2'd0;
        done_ack = 1'b0;
        #2;
        chk_val("rst_all_idle", 32'(all_idle), 32'd1);
        chk_val("rst_done_valid", 32'(done_valid), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_ready", 32'(assign_ready), 32'd7);
        do_reset();

        // Reset in the middle of a server2 task
        send(2'd1);
        tick();
        tick();
        chk_val("t1_busy_before_rst", 32'(busy), 32'b010);
        #3 reset = 1'b0;
        #1;
        chk_val("t1_pend2_rst", 32'(server2_pending), 32'd0);
        chk_val("t1_dv_rst", 32'(done_valid), 32'd0);
        chk_val("t1_idle_rst", 32'(all_idle), 32'd1);
        chk_val("t1_busy_rst", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        dv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_valid) dv_seen++;
        end
        chk_val("t1_no_report", 32'(dv_seen), 32'd0);

        // Single task to server3, ack tied high, latency check
        do_reset();
        done_ack = 1'b1;
        exp_q.push_back(2'd0);
        send(2'd0);
        chk_val("t2_pend_e0", 32'(server3_pending), 32'd1);
        n = 0;
        while (!done_valid && n < 20) begin
            tick();
            n++;
        end
        chk_val("t2_latency", 32'(n), 32'd5);
        chk_val("t2_srv", 32'(done_server), 32'd0);
        chk_val("t2_pend_before_ack", 32'(server3_pending), 32'd1);
        tick();
        chk_val("t2_pend_after_ack", 32'(server3_pending), 32'd0);
        chk_val("t2_idle", 32'(all_idle), 32'd1);
        chk_val("t2_dv_low", 32'(done_valid), 32'd0);
        done_ack = 1'b0;

        // One task per server, ack withheld, then round-robin drain
        do_reset();
        exp_q.push_back(2'd0);
        send(2'd0);
        exp_q.push_back(2'd1);
        send(2'd1);
        exp_q.push_back(2'd2);
        send(2'd2);
        n = 0;
        while (!done_valid && n < 20) begin
            tick();
            n++;
        end
        chk_val("t3_first_srv", 32'(done_server), 32'd0);
        dv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!done_valid || done_server != 2'd0) dv_seen++;
        end
        chk_val("t3_stable_unacked", 32'(dv_seen), 32'd0);
        chk_val("t3_all_done_busy", 32'(busy), 32'd0);
        chk_val("t3_pend_s1", 32'(server1_pending), 32'd1);
        done_ack = 1'b1;
        tick();
        chk_val("t3_second_srv", 32'(done_server), 32'd1);
        tick();
        chk_val("t3_third_srv", 32'(done_server), 32'd2);
        tick();
        done_ack = 1'b0;
        chk_val("t3_dv_end", 32'(done_valid), 32'd0);
        chk_val("t3_idle", 32'(all_idle), 32'd1);
        chk_val("t3_sb_left", 32'(exp_q.size()), 32'd0);

        // Fill server1 to the queue limit, then overflow once
        do_reset();
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(2'd2);
            send(2'd2);
        end
        chk_val("t4_pend_full", 32'(server1_pending), 32'd15);
        chk_val("t4_ready_full", 32'(assign_ready), 32'b011);
        send(2'd2);
        chk_val("t4_pend_overflow", 32'(server1_pending), 32'd15);
`ifdef TASK_EXEC_ERR_EN
        chk_val("t4_err", 32'(err_status), 32'b10);
`endif
        drain("t4", 200);

        // Accept and retire on server2 in the same edge
        do_reset();
        exp_q.push_back(2'd1);
        send(2'd1);
        exp_q.push_back(2'd1);
        send(2'd1);
        n = 0;
        while (!done_valid && n < 20) begin
            tick();
            n++;
        end
        chk_val("t5_srv", 32'(done_server), 32'd1);
        chk_val("t5_pend_pre", 32'(server2_pending), 32'd2);
        exp_q.push_back(2'd1);
        assign_valid  = 1'b1;
        assign_server = 2'd1;
        done_ack      = 1'b1;
        tick();
        assign_valid  = 1'b0;
        done_ack      = 1'b0;
        chk_val("t5_pend_post", 32'(server2_pending), 32'd2);
        chk_val("t5_busy", 32'(busy), 32'b010);
        chk_val("t5_dv_post", 32'(done_valid), 32'd0);
        drain("t5", 100);

        // Reserved index and stray ack
        do_reset();
        send(2'd3);
        chk_val("t6_pend3", 32'(server3_pending), 32'd0);
        chk_val("t6_pend2", 32'(server2_pending), 32'd0);
        chk_val("t6_pend1", 32'(server1_pending), 32'd0);
        chk_val("t6_idle", 32'(all_idle), 32'd1);
`ifdef TASK_EXEC_ERR_EN
        chk_val("t6_err", 32'(err_status), 32'b01);
`endif
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk_val("t6_stray_ack_dv", 32'(done_valid), 32'd0);
        chk_val("t6_stray_ack_ready", 32'(assign_ready), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/server_task_executor.md
Name: server_task_executor

Overview:
- Server-side counterpart of the task load balancer: receives per-server task assignments and models three servers (server1..server3) executing them.
- Each server queues its tasks and runs them one at a time for a fixed service time.
- Completions are reported back one at a time over a valid/ack handshake, so the dispatcher can retire load.
- Sits between the balancer's dispatch output and its load-retire input.

Parameters:
- SERVICE_CYCLES, 4, clock cycles a server spends on one task (legal range 1..15).
- QUEUE_MAX, 15, maximum pending tasks per server (must fit in 4 bits).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- assign_valid  input  1  task assignment offered this cycle.
- assign_server  input  2  target server: 0=server3, 1=server2, 2=server1, 3=reserved.
- assign_ready  output  3  per-server not-full flags, same index encoding; bit i = (pending_i < QUEUE_MAX).
- done_valid  output  1  a completion report is pending.
- done_server  output  2  server of the reported completion, same encoding.
- done_ack  input  1  dispatcher accepts the report.
- server3_pending  output  4  tasks held by server3 (queued + running + awaiting report).
- server2_pending  output  4  same for server2.
- server1_pending  output  4  same for server1.
- busy  output  3  per-server BUSY-state flags.
- all_idle  output  1  all pending counts are 0.

Behaviour:
- Reset (reset==0, asynchronous):
  - All pending counts = 0; every server FSM in IDLE; timers = 0; round-robin pointer = 0.
  - done_valid = 0, done_server = 0, busy = 0, all_idle = 1.
  - Reset mid-task discards all work; no completion is reported for it.
- Accept: a task is accepted on a rising edge when assign_valid=1, assign_server<3 and assign_ready[assign_server]=1.
  - Accepted: that server's pending increments by 1.
  - Not accepted (reserved index, or target full): the assignment is dropped silently and no count changes.
- Per-server FSM, three states:
  - IDLE: if pending>0 at an edge, go to BUSY and load timer = SERVICE_CYCLES-1.
  - BUSY: timer decrements each edge. At the edge where timer==0, go to DONE.
  - DONE: completion awaits report; the server starts nothing new.
- Latency: with no contention, a task accepted at edge E0 raises done_valid after edge E(SERVICE_CYCLES+1). With SERVICE_CYCLES=4, done_valid rises after the 5th edge.
- Reporting:
  - Round-robin arbitration among DONE servers. The search starts at the index after the last granted server, then wraps 2→0.
  - done_valid and done_server are registered and stay stable until an edge with done_ack=1. done_ack while done_valid=0 is ignored.
  - On the ack edge, the reported server's pending decrements by 1. It goes to BUSY (timer reloaded) if its remaining pending >0, otherwise to IDLE.
  - The next report may be presented the following cycle; at most one report per cycle.
- Simultaneous accept and retire on the same server in the same edge: pending is unchanged (net 0). The FSM still follows the retire rule above, using the updated count.
- Full boundary: pending==QUEUE_MAX drops assign_ready for that server. Pending never exceeds QUEUE_MAX and never wraps.
- busy[i] = 1 only in BUSY. all_idle = 1 when all three pending counts are 0.

Optional Feature:
- Macro: TASK_EXEC_ERR_EN.
- Defined:
  - Adds output err_status[1:0], cleared only by reset.
  - bit0 sets sticky on an assignment with assign_server==3.
  - bit1 sets sticky on an assignment to a full server.
- Undefined: the port is absent; such assignments are dropped silently with no other difference.

Test Plan:
- Reset with reset=0 mid-BUSY on server2 → all pending=0, done_valid=0, all_idle=1 immediately. No report after release.
- Single task to server3 (assign_server=0), SERVICE_CYCLES=4, done_ack tied 1 → done_valid high exactly after edge 5, done_server=0; server3_pending goes 1→0 on the ack edge.
- One task to each server on consecutive cycles, done_ack held 0 until all three are DONE, then ack each cycle → reports in order 0,1,2; done_server is stable while unacked.
- 15 tasks to server1 → assign_ready[2]=0 and server1_pending=15. A 16th assignment leaves the count at 15 (err_status[1]=1 when TASK_EXEC_ERR_EN is defined).
- Accept to server2 on the same edge that server2's report is acked with pending=2 → server2_pending stays 2 and the server re-enters BUSY.
- assign_server=3 with assign_valid=1 → no count changes (err_status[0]=1 with TASK_EXEC_ERR_EN).
